ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side companion for a DualPortRAM instance. On a start command the block streams a contiguous, wrapping address range out of the RAM's read port onto a valid/ready output stream. It absorbs the RAM's one-cycle read latency and handles downstream backpressure without losing or duplicating words. It sits between a buffer filled by a writer on the RAM's write port and a downstream consumer such as a packetiser or DMA.

## Interface
Parameters:
- Width, 8, data word width; must match the RAM.
- Depth, 1024, RAM depth in words; need not be a power of two.

Ports:
- ipClk  input  1  clock, shared with the RAM read port.
- ipReset  input  1  synchronous, active-low reset (reset when 0).
- ipStart  input  1  start pulse; sampled only in IDLE.
- ipBaseAddress  input  $clog2(Depth)  first address to read; sampled with ipStart.
- ipLength  input  $clog2(Depth)+1  number of words to read; sampled with ipStart.
- opBusy  output  1  high from the cycle after an accepted start until the transfer completes.
- opRdAddress  output  $clog2(Depth)  to RAM ipRdAddress.
- opRdEnable  output  1  to RAM ipRdEnable.
- ipRdData  input  Width  from RAM opRdData; valid the cycle after an enabled read.
- opData  output  Width  stream data.
- opValid  output  1  stream valid.
- ipReady  input  1  stream ready; handshake when opValid && ipReady at a rising edge.
- opLast  output  1  marks the final word; present only with STREAM_READER_LAST_EN.

## Operation
- FSM states:
  - IDLE: waits for a start.
  - RUN: issuing reads.
  - DRAIN: all reads issued, buffer not yet empty.
- IDLE -> RUN on ipStart=1 with ipLength!=0. ipStart with ipLength=0 is ignored.
- ipLength above Depth saturates to Depth.
- RUN -> DRAIN when the final read is issued.
- DRAIN -> IDLE on the handshake of the final word.
- ipStart in RUN or DRAIN is ignored and has no side effects.
- Address rules:
  - The first read uses ipBaseAddress.
  - Each issued read advances the address by 1.
  - Address Depth-1 wraps to 0.
- Output buffer: 2 entries, registered, in order.
  - opData/opValid come from the head entry.
  - A read is issued only when (occupancy + in-flight reads − pop this cycle) < 2, so no word is ever dropped.
- The remaining-reads counter decrements per issued read. The remaining-words counter decrements per handshake. Both are ipLength bits wide.
- opRdEnable is 0 in IDLE and DRAIN. opRdAddress holds its last value when not enabled.
- Reset: when ipReset=0 at an edge, all state clears regardless of the current state. Buffered and in-flight data are discarded, and in-flight RAM data is not captured.
- Reset values: opBusy=0, opValid=0, opRdEnable=0, opRdAddress=0, opData=0, opLast=0.

## Timing
- Edge E0 samples ipStart.
- Cycle after E0: opBusy=1, opRdEnable=1, opRdAddress=base.
- E1: the RAM registers the address.
- Cycle after E1: ipRdData is valid, and the block captures it at E2.
- Cycle after E2: opValid=1. Start-to-first-valid latency is 3 cycles.
- With ipReady held at 1, throughput is 1 word per cycle and there are no bubbles after the first word.
- While ipReady=0, opData and opValid hold stable, and opRdEnable drops once the buffer plus in-flight reads reach 2.
- When ipReady returns to 1, a handshake occurs in that same cycle. A new read is issued in the same cycle if the rule above allows.
- opBusy falls in the cycle after the final handshake. A new ipStart is accepted in that cycle.

## Configuration
- Macro: STREAM_READER_LAST_EN.
- Defined:
  - The opLast port exists.
  - opLast=1 exactly when the head entry is the final word of the transfer, and it is qualified by opValid.
  - opLast is tracked per buffer entry.
- Undefined: there is no opLast port and no last-tracking logic. All other behaviour is identical.

## Test plan
- Depth=16, prefilled RAM[i]=i.
  - Start base=3, length=4, ipReady=1 -> opData 3,4,5,6 on consecutive cycles, first valid 3 cycles after start, opLast only on 6, opBusy low the cycle after the final handshake.
  - Start base=14, length=5 -> 14,15,0,1,2 (wrap).
  - ipReady toggling pseudo-randomly, length=16 -> all 16 words in order exactly once, no opRdEnable while buffer plus in-flight equals 2, data stable while stalled.
- Control corner cases:
  - ipLength=0 -> opBusy stays 0, no opRdEnable.
  - ipLength=31 with Depth=16 -> exactly 16 words.
  - ipStart during RUN -> ignored, original transfer unaffected.
- Reset mid-transfer:
  - ipReset=0 for one cycle after the 2nd word -> all outputs 0 the next cycle, no further valid.
  - A subsequent start base=0, length=2 -> 0,1.
- Back-to-back transfers: start asserted the cycle opBusy falls -> accepted, second stream follows with the 3-cycle latency.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrapping address range from a DualPortRAM read port onto a
// valid/ready stream. Define STREAM_READER_LAST_EN to add the opLast end-of-transfer marker.
`timescale 1ns/1ps
module ram_stream_reader #(
  parameter int Width = 8,
  parameter int Depth = 1024
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  input  logic                     ipStart,
  input  logic [$clog2(Depth)-1:0] ipBaseAddress,
  input  logic [$clog2(Depth):0]   ipLength,
  output logic                     opBusy,
  output logic [$clog2(Depth)-1:0] opRdAddress,
  output logic                     opRdEnable,
  input  logic [Width-1:0]         ipRdData,
  output logic [Width-1:0]         opData,
  output logic                     opValid,
  input  logic                     ipReady
`ifdef STREAM_READER_LAST_EN
  ,
  output logic                     opLast
`endif
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(Depth - 1);
  localparam logic [LW-1:0] DEPTH_LEN = LW'(Depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [LW-1:0]   reads_left_reg, reads_left_next;
  logic [LW-1:0]   words_left_reg, words_left_next;
  logic            inflight_reg, inflight_next;
  logic [1:0]      count_reg, count_next;
  logic [Width-1:0] data_reg [2];
  logic [Width-1:0] data_next [2];

  logic [LW-1:0]   len_sat;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      room_used;
  logic [1:0]      wr_idx;

  assign len_sat = (ipLength > DEPTH_LEN) ? DEPTH_LEN : ipLength;

  assign opValid = (count_reg != 2'd0);
  assign pop     = opValid && ipReady;
  assign push    = inflight_reg;

  // Buffered plus in-flight words must stay below two after this cycle's pop.
  assign room_used = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign issue     = (state_reg == RUN) && (room_used < (3'd2 + {2'b00, pop}));

  assign opRdEnable  = issue;
  assign opRdAddress = addr_reg;
  assign opBusy      = (state_reg != IDLE);
  assign opData      = data_reg[0];

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    reads_left_next = reads_left_reg;
    words_left_next = words_left_reg;
    inflight_next   = issue;
    count_next      = count_reg + {1'b0, push} - {1'b0, pop};

    if (pop) begin
      words_left_next = words_left_reg - LW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (ipStart && (ipLength != '0)) begin
          state_next      = RUN;
          addr_next       = ipBaseAddress;
          reads_left_next = len_sat;
          words_left_next = len_sat;
        end
      end
      RUN: begin
        if (issue) begin
          addr_next       = (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
          reads_left_next = reads_left_reg - LW'(1);
          if (reads_left_reg == LW'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (words_left_reg == LW'(1))) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Entry 0 is the head; a pop shifts entry 1 down and a push lands just above the survivors.
  assign wr_idx = count_reg - {1'b0, pop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign data_next[gi] = (push && (wr_idx == 2'(gi))) ? ipRdData :
                           (pop && (gi == 0))           ? data_reg[1] :
                                                          data_reg[gi];
  end

  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      reads_left_reg <= '0;
      words_left_reg <= '0;
      inflight_reg   <= 1'b0;
      count_reg      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      reads_left_reg <= reads_left_next;
      words_left_reg <= words_left_next;
      inflight_reg   <= inflight_next;
      count_reg      <= count_next;
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= data_next[i];
      end
    end
  end

`ifdef STREAM_READER_LAST_EN
  logic inflight_last_reg, inflight_last_next;
  logic last_reg [2];
  logic last_next [2];

  assign inflight_last_next = issue && (reads_left_reg == LW'(1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_last
    assign last_next[gi] = (push && (wr_idx == 2'(gi))) ? inflight_last_reg :
                           (pop && (gi == 0))           ? last_reg[1] :
                                                          last_reg[gi];
  end

  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      inflight_last_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        last_reg[i] <= 1'b0;
      end
    end else begin
      inflight_last_reg <= inflight_last_next;
      for (int i = 0; i < 2; i++) begin
        last_reg[i] <= last_next[i];
      end
    end
  end

  assign opLast = opValid && last_reg[0];
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader (Depth=16, RAM[i]=i) with a handshake monitor.
`timescale 1ns/1ps
module tb_ram_stream_reader;

  logic       ipClk = 1'b0;
  logic       ipReset = 1'b0;
  logic       ipStart = 1'b0;
  logic [3:0] ipBaseAddress = 4'd0;
  logic [4:0] ipLength = 5'd0;
  logic       opBusy;
  logic [3:0] opRdAddress;
  logic       opRdEnable;
  logic [7:0] ipRdData = 8'd0;
  logic [7:0] opData;
  logic       opValid;
  logic       ipReady = 1'b1;
`ifdef STREAM_READER_LAST_EN
  logic       opLast;
`endif

  int total = 0;
  int bad = 0;
  logic rand_mode = 1'b0;

  always #5 ipClk = ~ipClk;

  ram_stream_reader #(.Width(8), .Depth(16)) dut (
    .ipClk(ipClk),
    .ipReset(ipReset),
    .ipStart(ipStart),
    .ipBaseAddress(ipBaseAddress),
    .ipLength(ipLength),
    .opBusy(opBusy),
    .opRdAddress(opRdAddress),
    .opRdEnable(opRdEnable),
    .ipRdData(ipRdData),
    .opData(opData),
    .opValid(opValid),
    .ipReady(ipReady)
`ifdef STREAM_READER_LAST_EN
    ,
    .opLast(opLast)
`endif
  );

  // RAM read port model: one-cycle registered read, prefilled with RAM[i]=i.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
  end
  always @(posedge ipClk) begin
    if (opRdEnable) ipRdData <= mem[opRdAddress];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Handshake monitor, sampled at the falling edge while inputs are settled.
  logic [7:0] got_q [$];
  logic       got_last_q [$];
  int         issued = 0;
  int         popped = 0;
  logic       hs;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'd0;

  always @(negedge ipClk) begin
    if (!ipReset) begin
      issued = 0;
      popped = 0;
      stall_prev = 1'b0;
    end else begin
      hs = opValid && ipReady;
      if (stall_prev) begin
        check_val("stall_valid", opValid, 1);
        check_val("stall_data", opData, stall_data);
      end
      if (opRdEnable) check_val("issue_room", ((issued - popped - int'(hs)) < 2), 1);
      if (hs) begin
        got_q.push_back(opData);
`ifdef STREAM_READER_LAST_EN
        got_last_q.push_back(opLast);
`else
        got_last_q.push_back(1'b0);
`endif
        $display("handshake: data=%0d", opData);
        popped++;
      end
      if (opRdEnable) issued++;
      stall_prev = opValid && !ipReady;
      stall_data = opData;
    end
  end

  task automatic tick();
    @(posedge ipClk);
    #1;
    if (rand_mode) ipReady = 1'($urandom_range(0, 1));
  endtask

  task automatic start_pulse(input logic [3:0] base, input logic [4:0] len);
    ipBaseAddress = base;
    ipLength = len;
    ipStart = 1'b1;
    tick();
    ipStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && opBusy; i++) tick();
    check_val({tag, "_idle"}, opBusy, 0);
  endtask

  task automatic check_stream(input string tag, input int base, input int n, input int len);
    check_val({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_val($sformatf("%s_d%0d", tag, i), got_q[i], (base + i) % 16);
`ifdef STREAM_READER_LAST_EN
      check_val($sformatf("%s_l%0d", tag, i), got_last_q[i], (i == len - 1) ? 1 : 0);
`endif
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    got_last_q.delete();
  endtask

  initial begin
    int lat;
    repeat (3) tick();
    check_val("rst_busy", opBusy, 0);
    check_val("rst_valid", opValid, 0);
    check_val("rst_rden", opRdEnable, 0);
    check_val("rst_addr", opRdAddress, 0);
    check_val("rst_data", opData, 0);
`ifdef STREAM_READER_LAST_EN
    check_val("rst_last", opLast, 0);
`endif
    ipReset = 1'b1;
    tick();

    // Basic transfer with latency and back-to-back output checks
    clear_q();
    start_pulse(4'd3, 5'd4);
    check_val("t1_busy", opBusy, 1);
    check_val("t1_rden", opRdEnable, 1);
    check_val("t1_addr", opRdAddress, 3);
    check_val("t1_valid_c1", opValid, 0);
    tick();
    check_val("t1_valid_c2", opValid, 0);
    tick();
    check_val("t1_valid_c3", opValid, 1);
    check_val("t1_first", opData, 3);
    lat = 0;
    while (opBusy && lat < 50) begin
      tick();
      lat++;
    end
    check_val("t1_cycles", lat, 4);
    check_val("t1_valid_end", opValid, 0);
    check_stream("t1", 3, 4, 4);

    // Wrapping range
    clear_q();
    start_pulse(4'd14, 5'd5);
    wait_idle("t2", 100);
    check_stream("t2", 14, 5, 5);

    // Random backpressure over a full-depth transfer
    clear_q();
    rand_mode = 1'b1;
    start_pulse(4'd5, 5'd16);
    wait_idle("t3", 600);
    rand_mode = 1'b0;
    ipReady = 1'b1;
    check_stream("t3", 5, 16, 16);

    // Zero length is ignored
    clear_q();
    start_pulse(4'd5, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("t4_busy", opBusy, 0);
      check_val("t4_rden", opRdEnable, 0);
      tick();
    end
    check_val("t4_count", got_q.size(), 0);

    // Length above depth saturates
    clear_q();
    start_pulse(4'd7, 5'd31);
    wait_idle("t5", 200);
    check_stream("t5", 7, 16, 16);

    // Starts during RUN and DRAIN are ignored
    clear_q();
    start_pulse(4'd2, 5'd6);
    tick();
    start_pulse(4'd9, 5'd3);
    repeat (4) tick();
    start_pulse(4'd12, 5'd2);
    wait_idle("t6", 100);
    check_stream("t6", 2, 6, 6);
    tick();
    check_val("t6_stay_idle", opBusy, 0);

    // Reset mid-transfer after the second word
    clear_q();
    start_pulse(4'd8, 5'd8);
    for (int i = 0; i < 50 && got_q.size() < 2; i++) tick();
    check_val("t7_two_words", got_q.size(), 2);
    ipReset = 1'b0;
    tick();
    ipReset = 1'b1;
    check_val("t7_busy", opBusy, 0);
    check_val("t7_valid", opValid, 0);
    check_val("t7_rden", opRdEnable, 0);
    check_val("t7_addr", opRdAddress, 0);
    check_val("t7_data", opData, 0);
`ifdef STREAM_READER_LAST_EN
    check_val("t7_last", opLast, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t7_no_valid", opValid, 0);
    end
    check_stream("t7", 8, 2, 8);
    clear_q();
    start_pulse(4'd0, 5'd2);
    wait_idle("t7b", 100);
    check_stream("t7b", 0, 2, 2);

    // Back-to-back: start on the cycle busy falls
    clear_q();
    start_pulse(4'd3, 5'd2);
    wait_idle("t8a", 100);
    check_stream("t8a", 3, 2, 2);
    clear_q();
    start_pulse(4'd10, 5'd3);
    check_val("t8_busy", opBusy, 1);
    check_val("t8_addr", opRdAddress, 10);
    check_val("t8_valid_c1", opValid, 0);
    tick();
    check_val("t8_valid_c2", opValid, 0);
    tick();
    check_val("t8_valid_c3", opValid, 1);
    check_val("t8_first", opData, 10);
    wait_idle("t8b", 100);
    check_stream("t8b", 10, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
